// File: rtl/exmem_mem_ctrl.sv
// EX/MEM memory-access controller: runs data-memory loads/stores over a req/ack
// handshake, holds the upstream register while busy, and registers write-back.
module exmem_mem_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  in_WC,
   input  logic [31:0] in_PC,
   input  logic [31:0] in_ALU_OUT,
   input  logic [31:0] in_PRB,
   input  logic [31:0] in_se_out,
   input  logic        in_W_DM,
   input  logic [1:0]  in_S_MXRB,
   input  logic        in_W_RB,
   input  logic [2:0]  in_W_RF,
   output logic        stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [3:0]  out_WC,
   output logic [31:0] out_WB_DATA,
   output logic        out_W_RB,
   output logic [2:0]  out_W_RF,
   output logic        bus_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_req;
   logic              r_err;
   logic              r_abort;
   logic [31:0]       r_rdata_q;
   logic [3:0]        r_wc;
   logic [31:0]       r_wb_data;
   logic              r_w_rb;
   logic [2:0]        r_w_rf;

   logic              w_mem_op;
   logic              w_stall;
   logic [31:0]       w_wb_sel;

   assign w_mem_op = in_W_DM | (in_S_MXRB == 2'b01);

   // Stall is combinational so the upstream register freezes in the same
   // cycle a memory op is first seen in IDLE.
   always_comb begin
      w_stall = 1'b0;
      if (!RESET) begin
         case (r_state)
            ST_IDLE:   w_stall = w_mem_op;
            ST_ACCESS: w_stall = 1'b1;
            default:   w_stall = 1'b0;
         endcase
      end
   end

   // Loads write back the captured data, never the live bus value.
   always_comb begin
      w_wb_sel = in_ALU_OUT;
      case (in_S_MXRB)
         2'b00:   w_wb_sel = in_ALU_OUT;
         2'b01:   w_wb_sel = r_rdata_q;
         2'b10:   w_wb_sel = in_PC + 32'd1;
         default: w_wb_sel = in_se_out;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_req     <= 1'b0;
         r_err     <= 1'b0;
         r_abort   <= 1'b0;
         r_rdata_q <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_abort <= 1'b0;
               if (w_mem_op) begin
                  r_state <= ST_ACCESS;
                  r_req   <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_ACCESS: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // An ack on the final allowed cycle still completes normally.
               if (dm_ack) begin
                  r_rdata_q <= dm_rdata;
                  r_req     <= 1'b0;
                  r_state   <= ST_DONE;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_abort <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wc      <= '0;
         r_wb_data <= '0;
         r_w_rb    <= 1'b0;
         r_w_rf    <= '0;
      end else if (w_stall) begin
         r_w_rb <= 1'b0;
         r_w_rf <= '0;
      end else begin
         r_wc      <= in_WC;
         r_wb_data <= w_wb_sel;
         if ((r_state == ST_DONE) && r_abort) begin
            r_w_rb <= 1'b0;
            r_w_rf <= '0;
         end else begin
            r_w_rb <= in_W_RB;
            r_w_rf <= in_W_RF;
         end
      end
   end

   assign stall       = w_stall;
   assign dm_req      = r_req;
   assign dm_we       = in_W_DM;
   assign dm_addr     = in_ALU_OUT;
   assign dm_wdata    = in_PRB;
   assign out_WC      = r_wc;
   assign out_WB_DATA = r_wb_data;
   assign out_W_RB    = r_w_rb;
   assign out_W_RF    = r_w_rf;
   assign bus_err     = r_err;

endmodule

// File: tb/tb_exmem_mem_ctrl.sv
// Bench for exmem_mem_ctrl: directed scenarios plus randomized back-to-back ops
// against a per-instruction timing/data model.
module tb_exmem_mem_ctrl;

   localparam int TIMEOUT = 16;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [3:0]  in_WC = '0;
   logic [31:0] in_PC = '0;
   logic [31:0] in_ALU_OUT = '0;
   logic [31:0] in_PRB = '0;
   logic [31:0] in_se_out = '0;
   logic        in_W_DM = 1'b0;
   logic [1:0]  in_S_MXRB = '0;
   logic        in_W_RB = 1'b0;
   logic [2:0]  in_W_RF = '0;
   logic        stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic [3:0]  out_WC;
   logic [31:0] out_WB_DATA;
   logic        out_W_RB;
   logic [2:0]  out_W_RF;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   // Model state: last committed write-back view, sticky error, last acked data.
   logic [3:0]  m_wc;
   logic [31:0] m_data;
   logic        m_err;
   logic [31:0] m_rdata_q;

   always #5 CLK = ~CLK;

   exmem_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .CLK(CLK), .RESET(RESET),
      .in_WC(in_WC), .in_PC(in_PC), .in_ALU_OUT(in_ALU_OUT), .in_PRB(in_PRB),
      .in_se_out(in_se_out), .in_W_DM(in_W_DM), .in_S_MXRB(in_S_MXRB),
      .in_W_RB(in_W_RB), .in_W_RF(in_W_RF),
      .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .out_WC(out_WC), .out_WB_DATA(out_WB_DATA), .out_W_RB(out_W_RB),
      .out_W_RF(out_W_RF), .bus_err(bus_err)
   );

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      m_wc      = '0;
      m_data    = '0;
      m_err     = 1'b0;
      m_rdata_q = '0;
   endtask

   task automatic zero_inputs();
      in_WC = '0; in_PC = '0; in_ALU_OUT = '0; in_PRB = '0; in_se_out = '0;
      in_W_DM = 1'b0; in_S_MXRB = '0; in_W_RB = 1'b0; in_W_RF = '0;
   endtask

   // Presents one instruction, holds it while stalled, and checks every cycle.
   // ack_at: ACCESS cycle (1-based) on which dm_ack pulses; 0 or >TIMEOUT = never.
   task automatic run_op(input string tag, input logic [3:0] wc, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] prb,
                         input logic [31:0] se, input logic wdm, input logic [1:0] smx,
                         input logic wrb, input logic [2:0] wrf, input int ack_at,
                         input logic [31:0] rdata);
      bit          mem;
      bit          abort;
      int          n_stall;
      logic        exp_req;
      logic [31:0] exp_data;
      logic [64:0] bus_obs;
      logic [64:0] bus_exp;
      mem     = wdm || (smx == 2'b01);
      abort   = mem && (ack_at < 1 || ack_at > TIMEOUT);
      n_stall = !mem ? 0 : (abort ? TIMEOUT + 1 : ack_at + 1);
      case (smx)
         2'b00:   exp_data = alu;
         2'b01:   exp_data = abort ? m_rdata_q : rdata;
         2'b10:   exp_data = pc + 32'd1;
         default: exp_data = se;
      endcase
      in_WC = wc; in_PC = pc; in_ALU_OUT = alu; in_PRB = prb; in_se_out = se;
      in_W_DM = wdm; in_S_MXRB = smx; in_W_RB = wrb; in_W_RF = wrf;
      for (int c = 0; c <= n_stall; c++) begin
         dm_ack   = mem && !abort && (c == ack_at);
         dm_rdata = dm_ack ? rdata : $urandom;
         @(negedge CLK);
         checks++;
         if (stall !== (c < n_stall)) begin
            errors++;
            $display("FAIL %s stall cycle %0d got %b want %b", tag, c, stall, (c < n_stall));
         end
         exp_req = mem && (c >= 1) && (c < n_stall);
         checks++;
         if (dm_req !== exp_req) begin
            errors++;
            $display("FAIL %s dm_req cycle %0d got %b want %b", tag, c, dm_req, exp_req);
         end
         if (c == 0) begin
            bus_obs = {dm_we, dm_addr, dm_wdata};
            bus_exp = {wdm, alu, prb};
            checks++;
            if (bus_obs !== bus_exp) begin
               errors++;
               $display("FAIL %s mem_bus got %h want %h", tag, bus_obs, bus_exp);
            end
         end
         @(posedge CLK);
         #1;
         dm_ack = 1'b0;
         if (c < n_stall) begin
            checks++;
            if ({out_W_RB, out_W_RF, out_WC, out_WB_DATA} !== {1'b0, 3'b000, m_wc, m_data}) begin
               errors++;
               $display("FAIL %s bubble cycle %0d got rb=%b rf=%b wc=%h d=%h want rb=0 rf=0 wc=%h d=%h",
                        tag, c, out_W_RB, out_W_RF, out_WC, out_WB_DATA, m_wc, m_data);
            end
         end
      end
      if (abort) m_err = 1'b1;
      if (mem && !abort) m_rdata_q = rdata;
      checks++;
      if ({out_W_RB, out_W_RF} !== (abort ? 4'b0000 : {wrb, wrf})) begin
         errors++;
         $display("FAIL %s wb_enables got rb=%b rf=%b want rb=%b rf=%b", tag, out_W_RB, out_W_RF,
                  abort ? 1'b0 : wrb, abort ? 3'b000 : wrf);
      end
      checks++;
      if ({out_WC, out_WB_DATA} !== {wc, exp_data}) begin
         errors++;
         $display("FAIL %s wb_data got wc=%h d=%h want wc=%h d=%h", tag, out_WC, out_WB_DATA,
                  wc, exp_data);
      end
      checks++;
      if (bus_err !== m_err) begin
         errors++;
         $display("FAIL %s bus_err got %b want %b", tag, bus_err, m_err);
      end
      m_wc   = wc;
      m_data = exp_data;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      in_S_MXRB = 2'b01; in_W_RB = 1'b1; in_W_RF = 3'b111; in_WC = 4'hF;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({stall, dm_req, bus_err, out_W_RB, out_W_RF, out_WC, out_WB_DATA} !== '0) begin
         errors++;
         $display("FAIL reset_state got stall=%b req=%b err=%b rb=%b rf=%b wc=%h d=%h want all 0",
                  stall, dm_req, bus_err, out_W_RB, out_W_RF, out_WC, out_WB_DATA);
      end
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      zero_inputs();
      model_reset();
   endtask

   task automatic test_alu();
      run_op("alu", 4'd5, 32'h100, 32'h1234, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 3'b101, 0, 32'h0);
   endtask

   task automatic test_load_delay();
      run_op("load_d3", 4'd7, 32'h200, 32'h40, 32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 3'b000, 3,
             32'hDEADBEEF);
      run_op("nop_after_load", 4'd1, 32'h201, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 3'b000, 0,
             32'h0);
   endtask

   task automatic test_store();
      run_op("store", 4'd2, 32'h300, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b1, 2'b00, 1'b0, 3'b000, 1,
             32'h11111111);
   endtask

   task automatic test_ack_at_limit();
      run_op("ack_at_limit", 4'd9, 32'h400, 32'h44, 32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 3'b010,
             TIMEOUT, 32'hCAFEF00D);
   endtask

   task automatic test_link_wrap();
      run_op("link_wrap", 4'd14, 32'hFFFFFFFF, 32'h5, 32'h0, 32'h0, 1'b0, 2'b10, 1'b1, 3'b000, 0,
             32'h0);
      run_op("se_imm", 4'd3, 32'h10, 32'h6, 32'h0, 32'hFFFFFF80, 1'b0, 2'b11, 1'b1, 3'b001, 0,
             32'h0);
   endtask

   task automatic test_timeout();
      run_op("timeout", 4'd6, 32'h500, 32'h80, 32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 3'b111, 0,
             32'h0);
      run_op("alu_after_to", 4'd4, 32'h501, 32'h77, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 3'b011, 0,
             32'h0);
   endtask

   task automatic test_reset_mid_access();
      in_WC = 4'd8; in_ALU_OUT = 32'h60; in_S_MXRB = 2'b01; in_W_RB = 1'b1; in_W_RF = 3'b110;
      @(posedge CLK);
      #1;
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      zero_inputs();
      @(negedge CLK);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid stall_in_reset got %b want 0", stall);
      end
      @(posedge CLK);
      #1;
      checks++;
      if ({stall, dm_req, bus_err, out_W_RB, out_W_RF, out_WC, out_WB_DATA} !== '0) begin
         errors++;
         $display("FAIL rst_mid after_edge got stall=%b req=%b err=%b rb=%b rf=%b wc=%h d=%h want all 0",
                  stall, dm_req, bus_err, out_W_RB, out_W_RF, out_WC, out_WB_DATA);
      end
      RESET = 1'b0;
      model_reset();
      dm_ack = 1'b1;
      dm_rdata = 32'h0BADF00D;
      @(posedge CLK);
      #1;
      dm_ack = 1'b0;
      checks++;
      if ({stall, dm_req, out_W_RB, out_WB_DATA} !== '0) begin
         errors++;
         $display("FAIL rst_mid late_ack got stall=%b req=%b rb=%b d=%h want all 0",
                  stall, dm_req, out_W_RB, out_WB_DATA);
      end
   endtask

   task automatic test_back_to_back();
      int r;
      int ack_at;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(9, 0);
         ack_at = (r == 0) ? 0 : r;
         run_op("b2b", 4'($urandom), $urandom, $urandom, $urandom, $urandom,
                1'($urandom_range(3, 0) == 0), 2'($urandom), 1'($urandom), 3'($urandom),
                ack_at, $urandom);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_alu();
      test_load_delay();
      test_store();
      test_ack_at_limit();
      test_link_wrap();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
